// File: rtl/cm_bus_responder.sv
// MCU-side endpoint of the 8-bit cm strobe/ack bus: synchronises the initiator's
// strobe and direction, queues received bytes in an RX FIFO and serves reads from a TX FIFO.
module cm_bus_responder #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter logic [7:0]  IDLE_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] cm,
    input  logic       cm_dir,
    input  logic       cm_stb,
    output logic       cm_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       rx_overflow,
    output logic       tx_underflow,
    output logic       bus_conflict
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(SETUP_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ACK   = 3'd1,
        ST_RD_SETUP = 3'd2,
        ST_RD_ACK   = 3'd3,
        ST_WAIT_LOW = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          stb_meta_q, stb_meta_d, stb_s_q, stb_s_d;
    logic          stb_dly_q, stb_dly_d, stb_rise_q, stb_rise_d;
    logic          dir_meta_q, dir_meta_d, dir_s_q, dir_s_d;
    logic          ack_q, ack_d, drv_en_q, drv_en_d;
    logic [7:0]    drv_q, drv_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, conf_q, conf_d;
    logic [AW:0]   rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [AW:0]   tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [7:0]    rx_mem_q [DEPTH];
    logic [7:0]    tx_mem_q [DEPTH];
    logic          rx_empty, rx_full, rx_pop, rx_push;
    logic          tx_empty, tx_full, tx_pop, tx_push;

    // Tristate bus driver: released whenever the responder is not sourcing a read byte.
    assign cm = drv_en_q ? drv_q : 8'bzzzz_zzzz;

    assign cm_ack       = ack_q;
    assign rx_data      = rx_mem_q[rx_rd_q[AW-1:0]];
    assign rx_valid     = ~rx_empty;
    assign tx_ready     = ~tx_full;
    assign rx_overflow  = ovf_q;
    assign tx_underflow = unf_q;
    assign bus_conflict = conf_q;

    // FIFO status, user-side handshakes and pointer advance.
    always_comb begin
        rx_empty = (rx_wr_q == rx_rd_q);
        rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
        tx_empty = (tx_wr_q == tx_rd_q);
        tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
        rx_pop   = rx_ready & ~rx_empty;
        tx_push  = tx_valid & ~tx_full;
        rx_wr_d  = rx_wr_q + {{AW{1'b0}}, rx_push};
        rx_rd_d  = rx_rd_q + {{AW{1'b0}}, rx_pop};
        tx_wr_d  = tx_wr_q + {{AW{1'b0}}, tx_push};
        tx_rd_d  = tx_rd_q + {{AW{1'b0}}, tx_pop};
    end

    // Synchroniser next values and the handshake FSM.
    always_comb begin
        stb_meta_d = cm_stb;
        stb_s_d    = stb_meta_q;
        stb_dly_d  = stb_s_q;
        stb_rise_d = stb_s_q & ~stb_dly_q;
        dir_meta_d = cm_dir;
        dir_s_d    = dir_meta_q;
        state_d    = state_q;
        ack_d      = ack_q;
        drv_en_d   = drv_en_q;
        drv_d      = drv_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        conf_d     = conf_q;
        rx_push    = 1'b0;
        tx_pop     = 1'b0;
        // The initiator turning the bus around while we drive overrides every state.
        if (drv_en_q && dir_s_q) begin
            drv_en_d = 1'b0;
            ack_d    = 1'b0;
            conf_d   = 1'b1;
            state_d  = ST_WAIT_LOW;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stb_rise_q && dir_s_q) begin
                        if (rx_full && !rx_pop) begin
                            ovf_d = 1'b1;
                        end else begin
                            rx_push = 1'b1;
                        end
                        ack_d   = 1'b1;
                        state_d = ST_WR_ACK;
                    end else if (stb_rise_q) begin
                        if (tx_empty) begin
                            drv_d = IDLE_BYTE;
                            unf_d = 1'b1;
                        end else begin
                            drv_d  = tx_mem_q[tx_rd_q[AW-1:0]];
                            tx_pop = 1'b1;
                        end
                        drv_en_d = 1'b1;
                        cnt_d    = CW'(SETUP_CYC);
                        state_d  = ST_RD_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_SETUP: begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_d   = {CW{1'b0}};
                        ack_d   = 1'b1;
                        state_d = ST_RD_ACK;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_WR_ACK, ST_RD_ACK: begin
                    if (!stb_s_q) begin
                        ack_d    = 1'b0;
                        drv_en_d = 1'b0;
                        state_d  = ST_WAIT_LOW;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WAIT_LOW: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    ack_d    = 1'b0;
                    drv_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // Control, synchroniser and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stb_meta_q <= 1'b0;
            stb_s_q    <= 1'b0;
            stb_dly_q  <= 1'b0;
            stb_rise_q <= 1'b0;
            dir_meta_q <= 1'b0;
            dir_s_q    <= 1'b0;
            ack_q      <= 1'b0;
            drv_en_q   <= 1'b0;
            drv_q      <= 8'h00;
            cnt_q      <= {CW{1'b0}};
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            conf_q     <= 1'b0;
            rx_wr_q    <= {(AW+1){1'b0}};
            rx_rd_q    <= {(AW+1){1'b0}};
            tx_wr_q    <= {(AW+1){1'b0}};
            tx_rd_q    <= {(AW+1){1'b0}};
        end else begin
            state_q    <= state_d;
            stb_meta_q <= stb_meta_d;
            stb_s_q    <= stb_s_d;
            stb_dly_q  <= stb_dly_d;
            stb_rise_q <= stb_rise_d;
            dir_meta_q <= dir_meta_d;
            dir_s_q    <= dir_s_d;
            ack_q      <= ack_d;
            drv_en_q   <= drv_en_d;
            drv_q      <= drv_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            conf_q     <= conf_d;
            rx_wr_q    <= rx_wr_d;
            rx_rd_q    <= rx_rd_d;
            tx_wr_q    <= tx_wr_d;
            tx_rd_q    <= tx_rd_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers mark them empty.
    always_ff @(posedge clk) begin
        if (rx_push && !rst) begin
            rx_mem_q[rx_wr_q[AW-1:0]] <= cm;
        end
        if (tx_push && !rst) begin
            tx_mem_q[tx_wr_q[AW-1:0]] <= tx_data;
        end
    end

endmodule

// File: tb/tb_cm_bus_responder.sv
// Directed bench for cm_bus_responder: plays the bus initiator and the user side,
// with scoreboard queues for received bytes and queued reply bytes.
module tb_cm_bus_responder;

    localparam int SETUP = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cm_dir, cm_stb, cm_ack;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready;
    logic       rx_overflow, tx_underflow, bus_conflict;
    logic       tb_drv;
    logic [7:0] tb_cm;
    wire  [7:0] cm;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    assign cm = tb_drv ? tb_cm : 8'bzzzz_zzzz;

    cm_bus_responder dut (
        .clk(clk), .rst(rst), .cm(cm), .cm_dir(cm_dir), .cm_stb(cm_stb), .cm_ack(cm_ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_overflow(rx_overflow), .tx_underflow(tx_underflow), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic probe(input int which);
        return (which == 0) ? cm_ack : dut.drv_en_q;
    endfunction

    // Wait (bounded) for cm_ack (which=0) or the bus driver enable (which=1) to reach want.
    task automatic wait_for(input string tag, input int which, input logic want, output int n);
        n = 0;
        while (probe(which) !== want && n < 40) begin
            step();
            n++;
        end
        chk(tag, probe(which), want);
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        if (tx_q.size() < 8) tx_q.push_back(b);
        step();
        tx_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] b, input bit check_lat);
        int n;
        tb_drv = 1'b1;
        tb_cm  = b;
        cm_dir = 1'b1;
        step();
        step();
        if (rx_q.size() < 8) rx_q.push_back(b);
        cm_stb = 1'b1;
        wait_for("wr_ack_high", 0, 1'b1, n);
        if (check_lat) chk("wr_ack_latency", n, 4);
        tb_drv = 1'b0;
        cm_stb = 1'b0;
        wait_for("wr_ack_low", 0, 1'b0, n);
        step();
        step();
    endtask

    task automatic bus_read();
        int n;
        logic [7:0] exp;
        exp    = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hEE;
        tb_drv = 1'b0;
        cm_dir = 1'b0;
        step();
        step();
        cm_stb = 1'b1;
        wait_for("rd_drive_on", 1, 1'b1, n);
        chk("rd_drive_latency", n, 4);
        chk("rd_data", cm, exp);
        wait_for("rd_ack_high", 0, 1'b1, n);
        chk("rd_setup_cycles", n, SETUP);
        chk("rd_data_at_ack", cm, exp);
        cm_stb = 1'b0;
        // Bus released two edges after the edge that first samples the strobe low.
        wait_for("rd_release", 1, 1'b0, n);
        chk("rd_release_latency", n, 3);
        chk("rd_ack_low", cm_ack, 1'b0);
        step();
        step();
    endtask

    task automatic rx_pop_check(input string tag);
        logic [7:0] exp;
        exp = rx_q.pop_front();
        chk({tag, "_valid"}, rx_valid, 1'b1);
        chk({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; cm_dir = 1'b0; cm_stb = 1'b0; tb_drv = 1'b0; tb_cm = 8'h00;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) step();
        chk("rst_ack", cm_ack, 1'b0);
        chk("rst_drv_en", dut.drv_en_q, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_flags", {rx_overflow, tx_underflow, bus_conflict}, 3'b000);
        rst = 1'b0;
        step();

        // Single write lands in the RX FIFO.
        bus_write(8'hA5, 1'b1);
        chk("t1_no_overflow", rx_overflow, 1'b0);
        rx_pop_check("t1_rx");
        chk("t1_rx_empty", rx_valid, 1'b0);

        // Read of a queued byte, then a read with TX empty.
        tx_push(8'h3C);
        bus_read();
        chk("t2_no_underflow", tx_underflow, 1'b0);
        bus_read();
        chk("t3_underflow", tx_underflow, 1'b1);

        // Nine writes into an 8-deep RX FIFO: the ninth is dropped.
        for (int i = 1; i <= 9; i++) begin
            bus_write(8'(i), 1'b0);
            chk("t4_overflow_timing", rx_overflow, (i == 9) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 8; i++) rx_pop_check("t4_rx");
        chk("t4_rx_drained", rx_valid, 1'b0);

        // Initiator turns the bus while we drive a read byte.
        tx_push(8'h77);
        tb_drv = 1'b0; cm_dir = 1'b0;
        step(); step();
        cm_stb = 1'b1;
        wait_for("t5_drive_on", 1, 1'b1, n);
        cm_dir = 1'b1;
        wait_for("t5_drive_off", 1, 1'b0, n);
        chk("t5_off_within_3", (n <= 3), 1'b1);
        chk("t5_conflict", bus_conflict, 1'b1);
        chk("t5_ack_low", cm_ack, 1'b0);
        void'(tx_q.pop_front());
        cm_stb = 1'b0; cm_dir = 1'b0;
        repeat (4) step();
        bus_read();
        bus_write(8'h5A, 1'b1);
        rx_pop_check("t5_rx");

        // Reset in the middle of a read acknowledge.
        for (int i = 0; i < 8; i++) tx_push(8'h10 + 8'(i));
        chk("t6_tx_full", tx_ready, 1'b0);
        bus_write(8'h22, 1'b0);
        tb_drv = 1'b0; cm_dir = 1'b0;
        step(); step();
        cm_stb = 1'b1;
        wait_for("t6_ack_high", 0, 1'b1, n);
        chk("t6_rd_data", cm, 8'h10);
        rst = 1'b1;
        step();
        chk("t6_ack_low", cm_ack, 1'b0);
        chk("t6_released", dut.drv_en_q, 1'b0);
        chk("t6_rx_empty", rx_valid, 1'b0);
        chk("t6_tx_ready", tx_ready, 1'b1);
        chk("t6_flags", {rx_overflow, tx_underflow, bus_conflict}, 3'b000);
        rst = 1'b0; cm_stb = 1'b0;
        rx_q.delete();
        tx_q.delete();
        repeat (3) step();
        bus_read();
        chk("t6_underflow_again", tx_underflow, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
